mdr_core: RTL and testbench
===========================

# mdr_core

Iterative signed multiply/divide/square-root engine, directly downstream of the operand-load stage. It consumes the latched operands DataX/DataY together with the start and flush strobes. It computes one result bit per clock and returns a one-cycle Ready pulse, which also returns the load stage's state machine to its idle state.

## Interface
- WORD_LENGTH, 16, operand width; must be even and at least 4.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  operation request; connects to the load stage's flagStart.
- Flush  input  1  synchronous abort/clear; connects to the load stage's flagFlush.
- Op  input  2  operation select: 00 MULT, 01 DIV, 10 SQRT, 11 reserved.
- DataX  input  WORD_LENGTH  two's-complement operand X (multiplicand / dividend / radicand).
- DataY  input  WORD_LENGTH  two's-complement operand Y (multiplier / divisor; ignored for SQRT).
- Result  output  2*WORD_LENGTH  product, quotient or root, sign-extended.
- Remainder  output  WORD_LENGTH  division or root remainder; 0 for MULT.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  high in every state except IDLE.
- Error  output  1  sticky until the next accepted Start, Flush or reset.

## Operation
- States: IDLE, LOAD, CALC, SIGN, DONE.
- IDLE:
  - Start=1 captures Op, DataX and DataY and goes to LOAD.
  - Start is ignored in all other states.
  - An accepted Start clears Error, Result and Remainder on the same edge.
- LOAD:
  - Forms the magnitudes |X| and |Y| and records the result sign.
  - Clears the accumulator and loads the iteration counter.
  - Error conditions (DIV with Y=0, SQRT with X<0, Op=11) set Error, force Result and Remainder to 0, and go directly to DONE.
- CALC, one bit per cycle:
  - MULT: shift-add over WORD_LENGTH cycles on magnitudes; 2*WORD_LENGTH-bit product.
  - DIV: restoring division over WORD_LENGTH cycles.
  - SQRT: digit-by-digit over WORD_LENGTH/2 cycles; root is floor(sqrt(X)), remainder is X - root².
  - The counter decrements each cycle; exit to SIGN when the counter reaches 0.
- SIGN:
  - MULT: negate the product if the signs differ.
  - DIV: quotient is truncated toward zero and negated if the signs differ; remainder takes the dividend's sign.
  - SQRT: no change.
  - Registers Result and Remainder, then goes to DONE.
- DONE: Ready=1 for exactly one cycle, then IDLE. Result, Remainder and Error hold until the next accepted Start, Flush or reset.
- Width rules: a full 2*WORD_LENGTH result never overflows. -2^(W-1) × -2^(W-1) and -2^(W-1) / -1 are both exact.
- Flush=1 on any edge:
  - Next state is IDLE.
  - Result, Remainder and Error are cleared and Ready=0.
  - Flush has priority over Start.
- reset low: immediately enters IDLE with all outputs 0, regardless of the current state.

## Timing
- Reset values: Result=0, Remainder=0, Ready=0, Busy=0, Error=0; state IDLE.
- Start sampled at edge 0:
  - LOAD occupies cycle 1.
  - CALC occupies cycles 2 to N+1 (N = WORD_LENGTH, or WORD_LENGTH/2 for SQRT).
  - SIGN occupies cycle N+2.
  - Ready is high during cycle N+3.
- Latency: 19 cycles for MULT/DIV and 11 for SQRT at the default width.
- Error latency: Ready is high during cycle 2 after the Start edge.
- Result and Remainder become valid on the edge entering DONE and are stable while Ready=1.
- Busy goes high the cycle after the Start edge and low the cycle after Ready.
- Start held high continuously: one operation per Start sampled in IDLE; back-to-back throughput is N+4 cycles.
- Start and Flush on the same edge: Flush wins and the operation is not accepted.

## Test plan
- MULT, X=7, Y=-3 -> Result=0xFFFF_FFEB, Remainder=0, Ready at cycle 19. Also X=-32768, Y=-32768 -> Result=0x4000_0000.
- DIV, X=-7, Y=2 -> Result=0xFFFF_FFFD, Remainder=0xFFFF. Also X=-32768, Y=-1 -> Result=0x0000_8000, Remainder=0.
- SQRT, X=200 -> Result=14, Remainder=4, Ready at cycle 11. Also X=0 -> Result=0, Remainder=0.
- Error cases: DIV with Y=0, SQRT with X=-4, and Op=11 -> Error=1, Result=0, Ready at cycle 2. The next valid Start clears Error.
- Flush at cycle 6 of a MULT -> IDLE next cycle, all outputs 0, no Ready pulse. Then a new DIV 100/7 -> Result=14, Remainder=2.
- reset driven low mid-CALC, between clock edges -> outputs 0 immediately. Start asserted during Busy is ignored, and the original result is unchanged.

Source files
------------

// File: rtl/mdr_core.sv
// mdr_core: iterative signed multiply / divide / square-root engine.
// One result bit is produced per clock. A one-cycle Ready pulse marks completion,
// and Result/Remainder/Error then hold until the next accepted Start, Flush or reset.
module mdr_core #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Start,
    input  logic                       Flush,
    input  logic [1:0]                 Op,
    input  logic [WORD_LENGTH-1:0]     DataX,
    input  logic [WORD_LENGTH-1:0]     DataY,
    output logic [2*WORD_LENGTH-1:0]   Result,
    output logic [WORD_LENGTH-1:0]     Remainder,
    output logic                       Ready,
    output logic                       Busy,
    output logic                       Error
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;

    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_HALF = CW'(W / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Working registers. r_q holds X (later its magnitude / quotient / product low half /
    // radicand shifter), r_b holds Y (later |Y| or the developing square root),
    // r_acc is the running upper product half / partial remainder.
    logic [1:0]     r_op;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_xneg;

    logic           w_err;
    logic [W-1:0]   w_absx;
    logic [W-1:0]   w_absy;
    logic [W:0]     w_mul_sum;
    logic [W:0]     w_div_shift;
    logic           w_div_ok;
    logic [W-1:0]   w_div_sub;
    logic [W+1:0]   w_sq_shift;
    logic [W+1:0]   w_sq_trial;
    logic           w_sq_ok;
    logic [W-1:0]   w_sq_sub;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_quo;
    logic [2*W-1:0] w_res_fin;
    logic [W-1:0]   w_rem_fin;

    // Operand checks and magnitudes; only meaningful while in LOAD (raw operands in r_q/r_b).
    assign w_err  = (r_op == 2'b11)
                  | ((r_op == OP_DIV)  && (r_b == {W{1'b0}}))
                  | ((r_op == OP_SQRT) && r_q[W-1]);
    assign w_absx = r_q[W-1] ? (-r_q) : r_q;
    assign w_absy = r_b[W-1] ? (-r_b) : r_b;

    // Shift-add multiply step: add multiplicand when the current multiplier bit is set.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(W+1){1'b0}});

    // Restoring divide step: bring down the next dividend bit and try to subtract |Y|.
    // The partial remainder is always below |Y|, so the W-bit difference is exact.
    assign w_div_shift = {r_acc, r_q[W-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[W-1:0] - r_b;

    // Digit-by-digit root step: bring down two radicand bits, trial value is 4*root+1.
    assign w_sq_shift = {r_acc, r_q[W-1:W-2]};
    assign w_sq_trial = {r_b, 2'b01};
    assign w_sq_ok    = (w_sq_shift >= w_sq_trial);
    assign w_sq_sub   = w_sq_shift[W-1:0] - w_sq_trial[W-1:0];

    assign w_prod = {r_acc, r_q};
    assign w_quo  = {{W{1'b0}}, r_q};

    // Sign correction applied in SIGN: negate product/quotient, remainder follows dividend.
    always_comb begin
        w_res_fin = {(2*W){1'b0}};
        w_rem_fin = {W{1'b0}};
        case (r_op)
            OP_MULT: begin
                w_res_fin = r_neg ? (-w_prod) : w_prod;
                w_rem_fin = {W{1'b0}};
            end
            OP_DIV: begin
                w_res_fin = r_neg ? (-w_quo) : w_quo;
                w_rem_fin = r_xneg ? (-r_acc) : r_acc;
            end
            OP_SQRT: begin
                w_res_fin = {{W{1'b0}}, r_b};
                w_rem_fin = r_acc;
            end
            default: begin
                w_res_fin = {(2*W){1'b0}};
                w_rem_fin = {W{1'b0}};
            end
        endcase
    end

    // Next-state logic; Flush overrides everything and returns to IDLE.
    always_comb begin
        w_next = r_state;
        if (Flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) w_next = S_LOAD;
                    else       w_next = S_IDLE;
                end
                S_LOAD: begin
                    if (w_err) w_next = S_DONE;
                    else       w_next = S_CALC;
                end
                S_CALC: begin
                    if (r_cnt == CNT_ONE) w_next = S_SIGN;
                    else                  w_next = S_CALC;
                end
                S_SIGN:  w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register with registered Ready (DONE is entered) and Busy (not IDLE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            Ready   <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            Ready   <= (w_next == S_DONE);
            Busy    <= (w_next != S_IDLE);
        end
    end

    // Datapath: capture, magnitude/setup, one iteration per cycle, sign fix-up and result hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= 2'b00;
            r_q       <= {W{1'b0}};
            r_b       <= {W{1'b0}};
            r_acc     <= {W{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_neg     <= 1'b0;
            r_xneg    <= 1'b0;
            Result    <= {(2*W){1'b0}};
            Remainder <= {W{1'b0}};
            Error     <= 1'b0;
        end else if (Flush) begin
            Result    <= {(2*W){1'b0}};
            Remainder <= {W{1'b0}};
            Error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op      <= Op;
                        r_q       <= DataX;
                        r_b       <= DataY;
                        Result    <= {(2*W){1'b0}};
                        Remainder <= {W{1'b0}};
                        Error     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_neg  <= r_q[W-1] ^ r_b[W-1];
                    r_xneg <= r_q[W-1];
                    r_q    <= w_absx;
                    r_b    <= (r_op == OP_SQRT) ? {W{1'b0}} : w_absy;
                    r_acc  <= {W{1'b0}};
                    r_cnt  <= (r_op == OP_SQRT) ? CNT_HALF : CNT_FULL;
                    if (w_err) begin
                        Error     <= 1'b1;
                        Result    <= {(2*W){1'b0}};
                        Remainder <= {W{1'b0}};
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    case (r_op)
                        OP_MULT: begin
                            r_acc <= w_mul_sum[W:1];
                            r_q   <= {w_mul_sum[0], r_q[W-1:1]};
                        end
                        OP_DIV: begin
                            r_acc <= w_div_ok ? w_div_sub : w_div_shift[W-1:0];
                            r_q   <= {r_q[W-2:0], w_div_ok};
                        end
                        OP_SQRT: begin
                            r_acc <= w_sq_ok ? w_sq_sub : w_sq_shift[W-1:0];
                            r_q   <= {r_q[W-3:0], 2'b00};
                            r_b   <= {r_b[W-2:0], w_sq_ok};
                        end
                        default: begin
                            r_acc <= r_acc;
                        end
                    endcase
                end
                S_SIGN: begin
                    Result    <= w_res_fin;
                    Remainder <= w_rem_fin;
                end
                S_DONE: begin
                    Result <= Result;
                end
                default: begin
                    Result <= Result;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_core.sv
// Self-checking bench for mdr_core: directed cases, randomized operations against an
// arithmetic reference model, flush, reset and Start-while-busy behaviour.
module tb_mdr_core;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        Flush;
    logic [1:0]  Op;
    logic [15:0] DataX;
    logic [15:0] DataY;
    logic [31:0] Result;
    logic [15:0] Remainder;
    logic        Ready;
    logic        Busy;
    logic        Error;

    int n_checks = 0;
    int n_errors = 0;

    mdr_core #(.WORD_LENGTH(16)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Op(Op),
        .DataX(DataX), .DataY(DataY), .Result(Result), .Remainder(Remainder),
        .Ready(Ready), .Busy(Busy), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the operands.
    task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] res, output logic [15:0] rem,
                         output logic err, output int lat);
        longint sx, sy, p, q, r, rt;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = 32'h0; rem = 16'h0; err = 1'b0; lat = 2;
        if (op == 2'b00) begin
            p = sx * sy; res = p[31:0]; lat = 19;
        end else if (op == 2'b01) begin
            if (sy == 0) err = 1'b1;
            else begin
                q = sx / sy; r = sx % sy;
                res = q[31:0]; rem = r[15:0]; lat = 19;
            end
        end else if (op == 2'b10) begin
            if (sx < 0) err = 1'b1;
            else begin
                rt = 0;
                while ((rt + 1) * (rt + 1) <= sx) rt++;
                r = sx - rt * rt;
                res = rt[31:0]; rem = r[15:0]; lat = 11;
            end
        end else begin
            err = 1'b1;
        end
    endtask

    // One full operation from Start to the cycle after Ready, checked against the model.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] x,
                          input logic [15:0] y);
        logic [31:0] eres; logic [15:0] erem; logic eerr; int elat; int cyc;
        model(op, x, y, eres, erem, eerr, elat);
        @(negedge clk);
        Start = 1'b1; Op = op; DataX = x; DataY = y;
        @(negedge clk);
        Start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        while (Ready !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(elat));
        check({tag, "_res"}, Result, eres);
        check({tag, "_rem"}, 32'(Remainder), 32'(erem));
        check({tag, "_err"}, 32'(Error), 32'(eerr));
        @(negedge clk);
        check({tag, "_rdy_pulse"}, 32'(Ready), 32'd0);
        check({tag, "_busy_low"}, 32'(Busy), 32'd0);
        check({tag, "_hold"}, Result, eres);
    endtask

    initial begin
        int c1, c2, cyc, seen;
        logic [1:0]  rop;
        logic [15:0] rx, ry;
        reset = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00; DataX = 16'h0; DataY = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_result", Result, 32'h0);
        check("rst_rem", 32'(Remainder), 32'h0);
        check("rst_ready", 32'(Ready), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_error", 32'(Error), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("mul_7_m3",    2'b00, 16'd7,      16'hFFFD);
        run_op("mul_min_min", 2'b00, 16'h8000,   16'h8000);
        run_op("div_m7_2",    2'b01, 16'hFFF9,   16'd2);
        run_op("div_min_m1",  2'b01, 16'h8000,   16'hFFFF);
        run_op("sqrt_200",    2'b10, 16'd200,    16'd0);
        run_op("sqrt_0",      2'b10, 16'd0,      16'd0);
        run_op("sqrt_max",    2'b10, 16'h7FFF,   16'd0);
        run_op("err_div0",    2'b01, 16'd5,      16'd0);
        run_op("err_sqrtneg", 2'b10, 16'hFFFC,   16'd0);
        run_op("err_op3",     2'b11, 16'd1,      16'd1);
        check("err_sticky", 32'(Error), 32'd1);
        run_op("after_err",   2'b00, 16'd3,      16'd4);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
            if (rop == 2'b10 && $urandom_range(0, 4) != 0) rx[15] = 1'b0;
            run_op("rand", rop, rx, ry);
        end

        // Flush in IDLE clears held result and error
        run_op("pre_flush", 2'b00, 16'd100, 16'd9);
        @(negedge clk); Flush = 1'b1;
        @(negedge clk); Flush = 1'b0;
        check("flush_idle_res", Result, 32'h0);
        run_op("pre_flush_err", 2'b11, 16'd0, 16'd0);
        @(negedge clk); Flush = 1'b1;
        @(negedge clk); Flush = 1'b0;
        check("flush_idle_err", 32'(Error), 32'h0);

        // Flush mid-MULT: back to IDLE, no Ready pulse afterwards
        @(negedge clk); Start = 1'b1; Op = 2'b00; DataX = 16'd1234; DataY = 16'd567;
        @(negedge clk); Start = 1'b0;
        repeat (4) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk); Flush = 1'b0;
        check("flush_busy", 32'(Busy), 32'h0);
        check("flush_res", Result, 32'h0);
        check("flush_rem", 32'(Remainder), 32'h0);
        check("flush_err", 32'(Error), 32'h0);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (Ready === 1'b1) seen++;
        end
        check("flush_no_ready", 32'(seen), 32'd0);
        run_op("div_100_7", 2'b01, 16'd100, 16'd7);

        // Start and Flush together: not accepted
        @(negedge clk); Start = 1'b1; Flush = 1'b1; Op = 2'b00; DataX = 16'd2; DataY = 16'd2;
        @(negedge clk); Start = 1'b0; Flush = 1'b0;
        check("start_flush_busy", 32'(Busy), 32'h0);

        // Start during Busy is ignored
        @(negedge clk); Start = 1'b1; Op = 2'b00; DataX = 16'd7; DataY = 16'hFFFD;
        @(negedge clk); Start = 1'b0; cyc = 1;
        repeat (3) begin @(negedge clk); cyc++; end
        Start = 1'b1; Op = 2'b01; DataX = 16'd50; DataY = 16'd3;
        repeat (4) begin @(negedge clk); cyc++; end
        Start = 1'b0;
        while (Ready !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        check("ign_lat", 32'(cyc), 32'd19);
        check("ign_res", Result, 32'hFFFF_FFEB);
        @(negedge clk);
        check("ign_idle", 32'(Busy), 32'h0);

        // Start held high: back-to-back throughput of N+4 cycles
        @(negedge clk); Start = 1'b1; Op = 2'b00; DataX = 16'd7; DataY = 16'hFFFD;
        cyc = 0; c1 = 0; c2 = 0;
        while (c2 == 0 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (Ready === 1'b1) begin
                if (c1 == 0) c1 = cyc;
                else c2 = cyc;
            end
        end
        Start = 1'b0;
        check("b2b_first", 32'(c1), 32'd19);
        check("b2b_period", 32'(c2 - c1), 32'd20);
        repeat (25) @(negedge clk);
        check("b2b_idle", 32'(Busy), 32'h0);

        // Asynchronous reset between edges during CALC
        @(negedge clk); Start = 1'b1; Op = 2'b01; DataX = 16'd999; DataY = 16'd7;
        @(negedge clk); Start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(Busy), 32'h0);
        check("arst_result", Result, 32'h0);
        @(negedge clk); reset = 1'b1;

        // Asynchronous reset while a result is held
        run_op("pre_arst", 2'b00, 16'd300, 16'd200);
        #2 reset = 1'b0;
        #1;
        check("arst_hold_res", Result, 32'h0);
        check("arst_hold_err", 32'(Error), 32'h0);
        @(negedge clk); reset = 1'b1;
        run_op("post_arst", 2'b10, 16'd144, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
